// File: rtl/frame_write_controller.sv
// Frame-buffer write sequencer: turns the registered pixel stream into addressed buffer writes.
// Optional `ROTATE_90_EN selects clockwise 90-degree rotated addressing instead of linear.
module frame_write_controller #(
    parameter int IMG_W  = 512,
    parameter int IMG_H  = 512,
    parameter int ADDR_W = 18
) (
    input  logic              Clk_in,
    input  logic              Rst_n,
    input  logic              pixel_ready,
    input  logic              pixel_valid,
    input  logic              line_end,
    input  logic [23:0]       pixel_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              err_len
);

    localparam int COL_W = $clog2(IMG_W + 1);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_FULL = COL_W'(IMG_W);
    localparam logic [COL_W:0]   ROW_LEN  = (COL_W + 1)'(IMG_W);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic              w_in_frame;
    logic              w_accept;
    logic              w_last_line;
    logic [COL_W:0]    w_row_cnt;
    logic [ADDR_W-1:0] w_addr;

    // pixel_ready restarts from any state, so it overrides normal in-frame handling
    assign w_in_frame  = (r_state == S_WRITE) && !pixel_ready;
    assign w_accept    = pixel_valid && (pixel_ready || (w_in_frame && (r_col < COL_FULL)));
    assign w_last_line = w_in_frame && line_end && (r_row == ROW_LAST);
    assign w_row_cnt   = {1'b0, r_col} + {{COL_W{1'b0}}, pixel_valid};

`ifdef ROTATE_90_EN
    localparam logic [ADDR_W-1:0] A_STEP  = ADDR_W'(IMG_H);
    localparam logic [ADDR_W-1:0] A_FIRST = ADDR_W'(IMG_H - 1);

    logic [ADDR_W-1:0] r_line_start;
    logic [ADDR_W-1:0] r_acc;

    assign w_addr = pixel_ready ? A_FIRST : r_acc;

    // r_line_start tracks IMG_H-1-row; r_acc walks down the output column by IMG_H per pixel
    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            r_line_start <= '0;
            r_acc        <= '0;
        end else if (pixel_ready) begin
            r_line_start <= A_FIRST;
            r_acc        <= pixel_valid ? (A_FIRST + A_STEP) : A_FIRST;
        end else if (w_in_frame) begin
            if (line_end) begin
                r_line_start <= r_line_start - ADDR_W'(1);
                r_acc        <= r_line_start - ADDR_W'(1);
            end else if (w_accept) begin
                r_acc <= r_acc + A_STEP;
            end
        end
    end
`else
    localparam logic [ADDR_W-1:0] A_STEP = ADDR_W'(IMG_W);

    logic [ADDR_W-1:0] r_row_base;

    assign w_addr = pixel_ready ? '0 : (r_row_base + ADDR_W'(r_col));

    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            r_row_base <= '0;
        end else if (pixel_ready) begin
            r_row_base <= '0;
        end else if (w_in_frame && line_end) begin
            r_row_base <= r_row_base + A_STEP;
        end
    end
`endif

    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        frame_done  = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (pixel_ready) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                busy = 1'b1;
                if (w_last_line) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy        = 1'b1;
                frame_done  = 1'b1;
                w_state_nxt = pixel_ready ? S_WRITE : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_in or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            r_row   <= '0;
            r_col   <= '0;
            err_len <= 1'b0;
        end else begin
            wr_en <= w_accept;
            if (w_accept) begin
                wr_addr <= w_addr;
                wr_data <= pixel_data;
            end
            if (pixel_ready) begin
                r_row   <= '0;
                r_col   <= pixel_valid ? COL_W'(1) : '0;
                err_len <= 1'b0;
            end else if (w_in_frame) begin
                if (line_end) begin
                    r_col <= '0;
                    r_row <= w_last_line ? '0 : (r_row + ROW_W'(1));
                    if (w_row_cnt != ROW_LEN) err_len <= 1'b1;
                end else if (pixel_valid) begin
                    if (r_col < COL_FULL) r_col <= r_col + COL_W'(1);
                    else                  err_len <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_write_controller.sv
// Randomized bench for frame_write_controller checked every cycle against a behavioural frame model.
// Honours `ROTATE_90_EN for the expected address mapping.
module tb_frame_write_controller;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pr = 1'b0;
    logic          pv = 1'b0;
    logic          le = 1'b0;
    logic [23:0]   pd = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          frame_done;
    logic          busy;
    logic          err_len;

    int n_vec = 0;
    int n_err = 0;

    // reference model: frame position and the outputs expected after each edge
    bit            m_in;
    bit            m_fd;
    bit            m_we;
    bit            m_err;
    int            m_row;
    int            m_col;
    logic [AW-1:0] m_addr;
    logic [23:0]   m_data;

    frame_write_controller #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .Clk_in     (clk),
        .Rst_n      (rst_n),
        .pixel_ready(pr),
        .pixel_valid(pv),
        .line_end   (le),
        .pixel_data (pd),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .busy       (busy),
        .err_len    (err_len)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_addr(input int r, input int c);
`ifdef ROTATE_90_EN
        return c * H + (H - 1 - r);
`else
        return r * W + c;
`endif
    endfunction

    task automatic model_reset();
        m_in = 0; m_fd = 0; m_we = 0; m_err = 0;
        m_row = 0; m_col = 0; m_addr = '0; m_data = '0;
    endtask

    task automatic model_write(input logic [23:0] d);
        m_we   = 1;
        m_addr = AW'(exp_addr(m_row, m_col));
        m_data = d;
    endtask

    task automatic model_step(input bit p_r, input bit p_v, input bit l_e, input logic [23:0] d);
        int cnt;
        m_we = 0;
        m_fd = 0;
        if (p_r) begin
            m_in = 1; m_row = 0; m_col = 0; m_err = 0;
            if (p_v) begin
                model_write(d);
                m_col = 1;
            end
        end else if (m_in) begin
            cnt = m_col + (p_v ? 1 : 0);
            if (p_v) begin
                if (m_col < W) begin
                    model_write(d);
                    m_col++;
                end else begin
                    m_err = 1;
                end
            end
            if (l_e) begin
                if (cnt != W) m_err = 1;
                m_col = 0;
                if (m_row == H - 1) begin
                    m_in = 0; m_fd = 1; m_row = 0;
                end else begin
                    m_row++;
                end
            end
        end
    endtask

    task automatic check_all();
        check_val("wr_en",      32'(wr_en),      32'(m_we));
        check_val("wr_addr",    32'(wr_addr),    32'(m_addr));
        check_val("wr_data",    32'(wr_data),    32'(m_data));
        check_val("frame_done", 32'(frame_done), 32'(m_fd));
        check_val("busy",       32'(busy),       32'(m_in || m_fd));
        check_val("err_len",    32'(err_len),    32'(m_err));
    endtask

    task automatic cycle(input bit p_r, input bit p_v, input bit l_e);
        logic [23:0] d;
        d  = 24'($urandom);
        pr = p_r; pv = p_v; le = l_e; pd = d;
        @(posedge clk);
        if (rst_n) model_step(p_r, p_v, l_e, d);
        #1;
        check_all();
        pr = 0; pv = 0; le = 0;
    endtask

    // n pixels; line_end on the last pixel (join) or on a separate cycle; optional random gaps
    task automatic send_row(input int n, input bit start, input bit join_le, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0) && !(start && i == 0)) cycle(0, 0, 0);
            cycle(start && (i == 0), 1, join_le && (i == n - 1));
        end
        if (!join_le) cycle(0, 0, 1);
    endtask

    task automatic send_frame(input bit bad, input bit gaps);
        int n;
        for (int r = 0; r < H; r++) begin
            n = W;
            if (bad && ($urandom_range(0, 2) == 0)) n = ($urandom_range(0, 1) == 0) ? W - 1 : W + 1;
            send_row(n, r == 0, 1'($urandom_range(0, 1)), gaps);
        end
    endtask

    task automatic junk(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        #3;
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        cycle(0, 1, 0);
        cycle(0, 1, 1);
        #3;
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        #12;
        rst_n = 1;
        cycle(0, 0, 0);

        // clean dense frame, then idle traffic that must be ignored
        for (int r = 0; r < H; r++) send_row(W, r == 0, 1, 0);
        cycle(0, 0, 0);
        junk(4);

        // short row, long row, then a normal row
        send_row(W - 1, 1, 0, 0);
        send_row(W + 1, 0, 0, 0);
        send_row(W, 0, 1, 0);
        cycle(0, 0, 0);

        // restart after six pixels
        send_row(W, 1, 1, 0);
        send_row(2, 0, 1, 0);
        send_frame(0, 0);
        cycle(0, 0, 0);

        // restart arriving in the DONE cycle
        for (int r = 0; r < H; r++) send_row(W, r == 0, 1, 0);
        send_frame(0, 1);

        // randomized frames with malformed rows, idle junk and aborted frames
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                send_row(W, 1, 1'($urandom_range(0, 1)), 1);
                send_row($urandom_range(1, W), 0, 1'($urandom_range(0, 1)), 1);
            end
            send_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            junk($urandom_range(0, 3));
        end

        // reset mid-frame, then a stream without pixel_ready, then a clean frame
        send_row(W, 1, 1, 0);
        cycle(0, 1, 0);
        do_reset();
        junk(6);
        send_row(W, 0, 1, 0);
        send_frame(0, 0);
        cycle(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
